// File: rtl/fetch_stage.sv
// fetch_stage -- instruction-fetch stage of the image-filter processor.
//
// Holds the PC, drives a synchronous-read instruction memory (1-cycle read
// latency) and presents the fetched instruction to Decode, already split into
// fields, together with the PC+4 of that instruction.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   stall_D         Decode cannot accept; hold PC, presented instruction, memory
//   branch_taken    redirect from execute; flushes the wrong-path fetch
//   branch_target   redirect byte address (low two bits ignored)
//   imem_addr       instruction-memory word address (pc_q[IMEM_AW+1:2])
//   imem_en         memory read enable; memory holds rdata while low
//   imem_rdata      instruction word, valid the cycle after imem_en
//   PCmas4_Out      PC of the presented instruction + 4
//   opcode, Rg_Out, Rp, Rs, imm24, imm16   instruction fields (0 on a bubble)
//   instr_valid     presented instruction is real
//   halted          fetch parked after a HALT opcode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 10,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_D,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        PCmas4_Out,
    output logic [3:0]         opcode,
    output logic [3:0]         Rg_Out,
    output logic [3:0]         Rp,
    output logic [3:0]         Rs,
    output logic [23:0]        imm24,
    output logic [15:0]        imm16,
    output logic               instr_valid,
    output logic               halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      fsm;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic [31:0] instr;
    logic        halt_hit;

    // A bubble is presented as the all-zero NOP.
    always_comb begin
        instr = '0;
        if (valid_q) begin
            instr = imem_rdata;
        end
    end

    assign imem_addr = pc_q[IMEM_AW+1:2];
    assign imem_en   = ((fsm == RUN) && !stall_D) || branch_taken;

    // HALT is only acted on once Decode actually takes it, so a stalled HALT
    // stays presented until the stall clears.
    assign halt_hit = (fsm == RUN) && valid_q && (instr[31:28] == HALT_OP) && !stall_D;

    assign opcode      = instr[31:28];
    assign Rg_Out      = instr[27:24];
    assign Rp          = instr[23:20];
    assign Rs          = instr[19:16];
    assign imm24       = instr[23:0];
    assign imm16       = instr[15:0];
    assign PCmas4_Out  = pc4_q;
    assign instr_valid = valid_q;
    assign halted      = (fsm == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fsm     <= RUN;
        end else if (branch_taken) begin
            // The fetch issued this cycle is wrong-path, so the next
            // presented slot is a bubble even if Decode was stalled.
            pc_q    <= branch_target & ~32'd3;
            valid_q <= 1'b0;
            fsm     <= RUN;
        end else if (fsm == HALT) begin
            valid_q <= 1'b0;
        end else if (halt_hit) begin
            fsm     <= HALT;
            valid_q <= 1'b0;
        end else if (!stall_D) begin
            pc4_q   <= pc_q + 32'd4;
            valid_q <= 1'b1;
            pc_q    <= pc_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// stall/branch/reset traffic. Expected instruction streams are generated as
// program paths (start address, +4 per instruction, ending at a HALT word)
// and queued per path; a negedge monitor pops and compares every instruction
// Decode accepts.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned IMEM_AW  = 10;
    localparam logic [3:0]  HALT_OP  = 4'hF;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               stall_D;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_rdata = '0;
    logic [31:0]        PCmas4_Out;
    logic [3:0]         opcode;
    logic [3:0]         Rg_Out;
    logic [3:0]         Rp;
    logic [3:0]         Rs;
    logic [23:0]        imm24;
    logic [15:0]        imm16;
    logic               instr_valid;
    logic               halted;

    logic [31:0] mem [0:1023];

    typedef struct {
        int unsigned seg;
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned stim_seg = 0;
    int unsigned cur_seg = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned n_accept = 0;
    bit          in_rst = 1'b0;
    bit          exp_halted = 1'b0;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .IMEM_AW (IMEM_AW),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_D      (stall_D),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .PCmas4_Out   (PCmas4_Out),
        .opcode       (opcode),
        .Rg_Out       (Rg_Out),
        .Rp           (Rp),
        .Rs           (Rs),
        .imm24        (imm24),
        .imm16        (imm16),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory; holds its output while disabled.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Queue the program path starting at t: sequential words up to and
    // including the first HALT word, with addresses wrapping modulo 2^32.
    task automatic push_path(input logic [31:0] t);
        logic [31:0] a;
        logic [31:0] w;
        exp_t        e;
        stim_seg++;
        a = t & ~32'd3;
        for (int k = 0; k < 1100; k++) begin
            w = mem[a[11:2]];
            e.seg  = stim_seg;
            e.addr = a;
            e.word = w;
            exp_q.push_back(e);
            if (w[31:28] == HALT_OP) break;
            a = a + 32'd4;
        end
    endtask

    task automatic cyc(input bit s, input bit b, input logic [31:0] t);
        @(posedge clk);
        #1;
        stall_D       = s;
        branch_taken  = b;
        branch_target = t;
        if (b) push_path(t);
    endtask

    // Reset asserted between clock edges; outputs must drop without an edge.
    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        push_path(RESET_PC);
        #1;
        chk("async_reset_drop", 64'({instr_valid, halted}), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        bit          halt_acc;
        logic [31:0] pc4_exp;
        halt_acc = 1'b0;
        if (!rst_n) begin
            if (!in_rst) begin
                cur_seg++;
                in_rst = 1'b1;
            end
            exp_halted = 1'b0;
            chk("reset_outputs", 64'({instr_valid, halted, opcode, Rg_Out, Rp, Rs, imm24, imm16}), 64'd0);
            chk("reset_pc4", 64'(PCmas4_Out), 64'd0);
            chk("reset_imem_en", 64'(imem_en), 64'(!stall_D));
        end else begin
            in_rst = 1'b0;
            chk("halted", 64'(halted), 64'(exp_halted));
            chk("imem_en", 64'(imem_en), 64'((!exp_halted && !stall_D) || branch_taken));
            if (instr_valid && !stall_D) begin
                while (exp_q.size() > 0 && exp_q[0].seg < cur_seg) void'(exp_q.pop_front());
                if (exp_q.size() == 0 || exp_q[0].seg != cur_seg) begin
                    n_total++;
                    $display("FAIL unexpected_instr: got pc4=%h word-fields valid, expected no instruction (t=%0t)",
                             PCmas4_Out, $time);
                end else begin
                    e = exp_q.pop_front();
                    pc4_exp = e.addr + 32'd4;
                    chk("fields", 64'({opcode, Rg_Out, Rp, Rs, imm24, imm16}),
                        64'({e.word[31:16], e.word[23:0], e.word[15:0]}));
                    chk("pc_plus4", 64'(PCmas4_Out), 64'(pc4_exp));
                    n_accept++;
                    halt_acc = (e.word[31:28] == HALT_OP);
                end
            end else if (!instr_valid) begin
                chk("bubble_fields", 64'({opcode, Rg_Out, Rp, Rs, imm24, imm16}), 64'd0);
            end
            if (branch_taken) begin
                cur_seg++;
                exp_halted = 1'b0;
            end else if (halt_acc) begin
                exp_halted = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        int unsigned hcnt;
        bit          s;
        bit          b;
        logic [31:0] t;

        for (int unsigned n = 0; n < 1024; n++) begin
            if (n < 64) begin
                mem[n] = 32'h1000_0000 + n;
            end else begin
                w = $urandom;
                if (w[31:28] == HALT_OP) w[31:28] = 4'h0;
                mem[n] = w;
            end
            if (n % 37 == 20) mem[n] = {HALT_OP, 28'(n)};
        end
        mem[3] = 32'hF000_0000;

        rst_n         = 1'b0;
        stall_D       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        push_path(RESET_PC);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Free-run from reset, 3-cycle stall, then run into HALT at 0xC.
        repeat (2) cyc(1'b0, 1'b0, 32'h0);
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        repeat (6) cyc(1'b0, 1'b0, 32'h0);
        repeat (2) cyc(1'b1, 1'b0, 32'h0);
        // Resume via branch to 0, then redirect to 0x41 under stall.
        cyc(1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0000_0041);
        repeat (8) cyc(1'b0, 1'b0, 32'h0);
        // PC wrap-around, then reset mid-stall.
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (2) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        reset_pulse();
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        hcnt = 0;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom % 4 == 0);
            b = ($urandom % 10 == 0);
            t = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
            if (halted) hcnt++;
            else hcnt = 0;
            if (hcnt >= 3) b = 1'b1;
            if ($urandom % 250 == 0) reset_pulse();
            else cyc(s, b, t);
        end
        repeat (3) cyc(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        chk("accepted_count_min", 64'(n_accept >= 100), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
